seg_mux_scan: RTL and testbench
===============================

SEG_MUX_SCAN -- requirements
Module: seg_mux_scan

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000; clock cycles per digit slot (legal: 4..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 1000; cycles all-off at the start of each slot (legal: 1..TICK_DIV-2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64; frames per blink half-period (used only when blink is compiled in).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  scan enable; 0 forces the display dark.
REQ-007 d1, d2, d3, d4  input  7 each  active-high segment patterns (bit0=a .. bit6=g); d1 is the rightmost digit.
REQ-008 blink  input  1  flash request; exists only when SEG_MUX_BLINK_EN is defined.
REQ-009 an  output  4  active-low anodes; an[0] drives the d1 digit, an[3] drives the d4 digit.
REQ-010 seg  output  7  active-low cathodes, equal to the bitwise inverse of the selected pattern.
REQ-011 digit_idx  output  2  index of the slot currently being scanned.
REQ-012 frame_done  output  1  one-cycle pulse at the end of digit 3's slot.

Function
REQ-013 SHALL implement FSM states IDLE, BLANK and DRIVE; all outputs registered and updated on the same edge as the state.
REQ-014 IDLE: an=4'b1111, seg=7'b1111111; on en=1, next state is BLANK, digit_idx=0, and the shadow registers load d1..d4.
REQ-015 BLANK: an=4'b1111, seg=7'b1111111 for exactly BLANK_CYC cycles, then DRIVE.
REQ-016 DRIVE: an has only bit digit_idx low, seg=~shadow[digit_idx], for exactly TICK_DIV-BLANK_CYC cycles.
REQ-017 Slot end: digit_idx increments mod 4 and the next state is BLANK; total slot length SHALL be exactly TICK_DIV cycles.
REQ-018 End of slot 3: frame_done=1 for one cycle, digit_idx wraps to 0, and the shadows reload from d1..d4 on that same edge.
REQ-019 Changes on d1..d4 mid-frame SHALL NOT appear until the next frame (tear-free display).
REQ-020 en=0 in any state: next cycle is IDLE with outputs dark, digit_idx=0, slot counter cleared, and no frame_done.
REQ-021 rst and en=1 in the same cycle: rst wins.

Reset
REQ-022 rst SHALL give: state IDLE, an=4'b1111, seg=7'b1111111, digit_idx=0, frame_done=0, counters=0, shadows=0, blink phase=0; it takes effect on the next edge from any state.

Configuration
REQ-023 With SEG_MUX_BLINK_EN defined: a frame counter runs while scanning; when blink=1, the display alternates BLINK_FRAMES frames normal then BLINK_FRAMES frames dark (an=4'b1111), and scanning and frame_done continue throughout; blink=0 restores a normal display at the next frame boundary.
REQ-024 Without SEG_MUX_BLINK_EN: no blink port and no frame counter; behaviour is exactly REQ-013..REQ-021.

Structure
REQ-025 Package seg_scan_pkg SHALL hold the state enum, SEG_OFF=7'b1111111 and AN_OFF=4'b1111.
REQ-026 One sub-module, seg_slot_timer, SHALL provide the slot counter and its blank_end/slot_end strobes; the FSM and shadows stay in the top level.

Verification (TICK_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-027 d1=7'h06, d2=7'h5B, d3=7'h4F, d4=7'h66, en rising -> 2 dark cycles, then an=4'b1110 with seg=7'h79 for 6 cycles, then 2 dark cycles, then an=4'b1101 with seg=7'h24, continuing through 4'b1011 and 4'b0111.
REQ-028 Free-running scan -> frame_done pulses every 32 cycles, each pulse coincident with digit_idx wrapping 3->0.
REQ-029 d2 changed to 7'h3F while digit 0 is being driven -> the old d2 pattern is shown in this frame; seg=7'h40 appears on an=4'b1101 only in the next frame.
REQ-030 en dropped during the DRIVE of digit 2 -> the next cycle shows an=4'b1111 and digit_idx=0; re-asserting en restarts at digit 0.
REQ-031 rst pulsed mid-BLANK and mid-DRIVE -> all reset values on the next edge; rst together with en=1 -> stays in IDLE.
REQ-032 (SEG_MUX_BLINK_EN) blink=1 -> 2 frames lit, then 2 frames with an=4'b1111, repeating, and frame_done continues every 32 cycles.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

   localparam logic [6:0] SEG_OFF    = 7'b1111111;
   localparam logic [3:0] AN_OFF     = 4'b1111;
   localparam int         NUM_DIGITS = 4;

   // Active-low anode vector with only the selected digit enabled.
   function automatic logic [3:0] anode_sel(input logic [1:0] idx);
      logic [3:0] one_hot;
      one_hot = 4'b0001 << idx;
      return ~one_hot;
   endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter for the digit scanner: counts 0..TICK_DIV-1 while run is high
// and flags the last blanking cycle and the last cycle of the slot.
module seg_slot_timer #(
   parameter int TICK_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic blank_end,
   output logic slot_end
);

   localparam int            CW         = $clog2(TICK_DIV);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (!run) begin
         cnt_next = '0;
      end else if (cnt_reg == SLOT_LAST) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_reg + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign blank_end = run && (cnt_reg == BLANK_LAST);
   assign slot_end  = run && (cnt_reg == SLOT_LAST);

endmodule

// File: rtl/seg_mux_scan.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking and
// frame-latched patterns. Optional flashing is built when SEG_MUX_BLINK_EN is defined.
module seg_mux_scan
   import seg_scan_pkg::*;
#(
   parameter int TICK_DIV     = 100000,
   parameter int BLANK_CYC    = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
`ifdef SEG_MUX_BLINK_EN
   input  logic       blink,
`endif
   input  logic [6:0] d1,
   input  logic [6:0] d2,
   input  logic [6:0] d3,
   input  logic [6:0] d4,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic [1:0] digit_idx,
   output logic       frame_done
);

   if (TICK_DIV < 4 || TICK_DIV > (1 << 20) || BLANK_CYC < 1 ||
       BLANK_CYC > TICK_DIV - 2 || BLINK_FRAMES < 1) begin : g_param_check
      $error("seg_mux_scan: illegal parameter combination");
   end

   scan_state_t state_reg, state_next;
   logic [1:0]  digit_idx_reg, digit_idx_next;
   logic [3:0]  an_reg, an_next;
   logic [6:0]  seg_reg, seg_next;
   logic        frame_done_reg, frame_done_next;
   logic        load_shadow, frame_end, dark_next;
   logic        run, blank_end, slot_end;
   logic [6:0]  d_in   [NUM_DIGITS];
   logic [6:0]  shadow [NUM_DIGITS];

   assign run = en && (state_reg != IDLE);

   seg_slot_timer #(
      .TICK_DIV  (TICK_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .blank_end (blank_end),
      .slot_end  (slot_end)
   );

   assign d_in[0] = d1;
   assign d_in[1] = d2;
   assign d_in[2] = d3;
   assign d_in[3] = d4;

   // Patterns are captured only at frame start so a digit never tears mid-frame.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shadow
      logic [6:0] pat_reg;
      always_ff @(posedge clk) begin
         if (rst) begin
            pat_reg <= '0;
         end else if (load_shadow) begin
            pat_reg <= d_in[gi];
         end
      end
      assign shadow[gi] = pat_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         digit_idx_reg  <= '0;
         an_reg         <= AN_OFF;
         seg_reg        <= SEG_OFF;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         digit_idx_reg  <= digit_idx_next;
         an_reg         <= an_next;
         seg_reg        <= seg_next;
         frame_done_reg <= frame_done_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      digit_idx_next = digit_idx_reg;
      load_shadow    = 1'b0;
      frame_end      = 1'b0;
      if (!en) begin
         state_next     = IDLE;
         digit_idx_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_next     = BLANK;
               digit_idx_next = '0;
               load_shadow    = 1'b1;
            end
            BLANK: begin
               if (blank_end) state_next = DRIVE;
            end
            DRIVE: begin
               if (slot_end) begin
                  state_next     = BLANK;
                  digit_idx_next = digit_idx_reg + 2'd1;
                  if (digit_idx_reg == 2'd3) begin
                     frame_end   = 1'b1;
                     load_shadow = 1'b1;
                  end
               end
            end
            default: begin
               state_next     = IDLE;
               digit_idx_next = '0;
            end
         endcase
      end
   end

   // Outputs are derived from the next state so they change on the same edge.
   always_comb begin
      an_next         = AN_OFF;
      seg_next        = SEG_OFF;
      frame_done_next = frame_end;
      if (state_next == DRIVE && !dark_next) begin
         an_next  = anode_sel(digit_idx_next);
         seg_next = ~shadow[digit_idx_next];
      end
   end

`ifdef SEG_MUX_BLINK_EN
   localparam int            FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
   logic          phase_reg, phase_next;
   logic          dark_reg;

   // Phase flips every BLINK_FRAMES frames; the blink request is sampled per frame.
   always_comb begin
      frame_cnt_next = frame_cnt_reg;
      phase_next     = phase_reg;
      dark_next      = dark_reg;
      if (state_next == IDLE) begin
         frame_cnt_next = '0;
         phase_next     = 1'b0;
         dark_next      = 1'b0;
      end else begin
         if (frame_end) begin
            if (frame_cnt_reg == FRAME_LAST) begin
               frame_cnt_next = '0;
               phase_next     = ~phase_reg;
            end else begin
               frame_cnt_next = frame_cnt_reg + FW'(1);
            end
         end
         if (load_shadow) dark_next = blink & phase_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_reg <= '0;
         phase_reg     <= 1'b0;
         dark_reg      <= 1'b0;
      end else begin
         frame_cnt_reg <= frame_cnt_next;
         phase_reg     <= phase_next;
         dark_reg      <= dark_next;
      end
   end
`else
   assign dark_next = 1'b0;
`endif

   assign an         = an_reg;
   assign seg        = seg_reg;
   assign digit_idx  = digit_idx_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_mux_scan.sv
// Scoreboard bench for seg_mux_scan: a cycle-position reference model queues
// expected outputs at each edge and a negedge monitor compares them.
module tb_seg_mux_scan;

   localparam int TICK_DIV     = 8;
   localparam int BLANK_CYC    = 2;
   localparam int BLINK_FRAMES = 2;
   localparam int FRAME        = 4 * TICK_DIV;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic [1:0] idx;
      logic       fd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [6:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
`ifdef SEG_MUX_BLINK_EN
   logic       blink = 1'b0;
`endif
   logic [3:0] an;
   logic [6:0] seg;
   logic [1:0] digit_idx;
   logic       frame_done;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   fd_seen = 0;
   int   fd_expected = 0;

   seg_mux_scan #(
      .TICK_DIV     (TICK_DIV),
      .BLANK_CYC    (BLANK_CYC),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
`ifdef SEG_MUX_BLINK_EN
      .blink      (blink),
`endif
      .d1         (d1),
      .d2         (d2),
      .d3         (d3),
      .d4         (d4),
      .an         (an),
      .seg        (seg),
      .digit_idx  (digit_idx),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Reference model: p counts cycles since scanning started; every output
   // follows from p by slot arithmetic and the per-frame snapshot of d1..d4.
   bit         scanning = 1'b0;
   int         p = 0;
   logic [6:0] snap [4];
   bit         snap_blink = 1'b0;

   always @(posedge clk) begin : model
      exp_t       e;
      int         slot;
      int         off;
      bit         lit;
      logic [3:0] one_hot;
      if (rst || !en) begin
         scanning = 1'b0;
      end else if (!scanning) begin
         scanning = 1'b1;
         p        = 0;
         snap[0] = d1; snap[1] = d2; snap[2] = d3; snap[3] = d4;
`ifdef SEG_MUX_BLINK_EN
         snap_blink = blink;
`endif
      end else begin
         p = p + 1;
         if (p % FRAME == 0) begin
            snap[0] = d1; snap[1] = d2; snap[2] = d3; snap[3] = d4;
`ifdef SEG_MUX_BLINK_EN
            snap_blink = blink;
`endif
         end
      end
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      e.idx = 2'd0;
      e.fd  = 1'b0;
      if (scanning) begin
         slot  = (p / TICK_DIV) % 4;
         off   = p % TICK_DIV;
         e.idx = 2'(slot);
         e.fd  = (p > 0) && (p % FRAME == 0);
         lit   = (off >= BLANK_CYC);
         if (snap_blink && (((p / FRAME) / BLINK_FRAMES) % 2 == 1)) lit = 1'b0;
         if (lit) begin
            one_hot = 4'b0001 << slot;
            e.an    = ~one_hot;
            e.seg   = ~snap[slot];
         end
      end
      if (e.fd) fd_expected++;
      exp_q.push_back(e);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (frame_done === 1'b1) fd_seen++;
         check("an",         {28'd0, an},         {28'd0, e.an});
         check("seg",        {25'd0, seg},        {25'd0, e.seg});
         check("digit_idx",  {30'd0, digit_idx},  {30'd0, e.idx});
         check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      tick(2);
      rst = 1'b0;
      tick(2);

      $display("txn: digits 1-2-3-4 scan, d2 changed during digit 0");
      d1 = 7'h06; d2 = 7'h5B; d3 = 7'h4F; d4 = 7'h66;
      en = 1'b1;
      tick(4);
      d2 = 7'h3F;
      tick(70);

      $display("txn: en dropped during digit 2 drive, then restart");
      en = 1'b0;
      tick(1);
      en = 1'b1;
      tick(20);
      en = 1'b0;
      tick(3);
      en = 1'b1;
      tick(40);

      $display("txn: rst mid-BLANK, rst mid-DRIVE, rst with en");
      en = 1'b0;
      tick(1);
      en = 1'b1;
      tick(9);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(12);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(40);

`ifdef SEG_MUX_BLINK_EN
      $display("txn: blink on then off");
      en = 1'b0;
      blink = 1'b1;
      tick(1);
      en = 1'b1;
      tick(6 * FRAME);
      blink = 1'b0;
      tick(2 * FRAME);
`endif

      $display("txn: randomized traffic");
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(299, 0) == 0);
         if ($urandom_range(199, 0) == 0) en = ~en;
         else if (!en && $urandom_range(9, 0) == 0) en = 1'b1;
         if ($urandom_range(7, 0) == 0) begin
            case ($urandom_range(3, 0))
               0: d1 = 7'($urandom);
               1: d2 = 7'($urandom);
               2: d3 = 7'($urandom);
               default: d4 = 7'($urandom);
            endcase
         end
`ifdef SEG_MUX_BLINK_EN
         if ($urandom_range(149, 0) == 0) blink = ~blink;
`endif
         tick(1);
      end
      rst = 1'b0;
      tick(2);
      @(negedge clk);
      #1;
      check("frame_done_count", fd_seen, fd_expected);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
